// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================
// mem_arb_pkg: shared types and defaults for mem_port_arbiter
// Revision: 1.0
// ============================================================
`default_nettype none

package mem_arb_pkg;

    localparam int ADDR_W_DEF         = 32;
    localparam int DATA_W_DEF         = 256;
    localparam int TIMEOUT_CYCLES_DEF = 1024;
    localparam int CNT_W_DEF          = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_select.sv
// ============================================================
// rr_select: two-way round-robin winner selection
// Revision: 1.0
// ============================================================
`default_nettype none

module rr_select (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       any_o,
    output logic       winner_o
);

    // On a tie the port that did not win last time goes next.
    always_comb begin
        any_o    = |req_i;
        winner_o = (req_i == 2'b11) ? ~last_i : req_i[1];
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================
// mem_port_arbiter: round-robin sharing of one memory port between I$ and D$
// Revision: 1.0
// ============================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_enable_i,
    input  logic              req0_write_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic [DATA_W-1:0] req0_data_o,
    output logic              req0_ack_o,
    input  logic              req1_enable_i,
    input  logic              req1_write_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic [DATA_W-1:0] req1_data_o,
    output logic              req1_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic              busy_o,
    output logic              timeout_o
);

    arb_state_e        state_q;
    logic              owner_q;
    logic              rr_last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              mem_enable_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic [DATA_W-1:0] req0_data_q;
    logic [DATA_W-1:0] req1_data_q;
    logic              req0_ack_q;
    logic              req1_ack_q;
    logic              busy_q;
    logic              timeout_q;

    logic              any_d;
    logic              winner_d;
    logic              cmd_write_d;
    logic [ADDR_W-1:0] cmd_addr_d;
    logic [DATA_W-1:0] cmd_data_d;
    logic [CNT_W-1:0]  cnt_inc_d;

    rr_select u_rr_select (
        .req_i    ({req1_enable_i, req0_enable_i}),
        .last_i   (rr_last_q),
        .any_o    (any_d),
        .winner_o (winner_d)
    );

    always_comb begin
        cmd_write_d = (winner_d == PORT_D) ? req1_write_i : req0_write_i;
        cmd_addr_d  = (winner_d == PORT_D) ? req1_addr_i  : req0_addr_i;
        cmd_data_d  = (winner_d == PORT_D) ? req1_data_i  : req0_data_i;
        cnt_inc_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            owner_q      <= PORT_I;
            rr_last_q    <= PORT_D;
            cnt_q        <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            req0_data_q  <= '0;
            req1_data_q  <= '0;
            req0_ack_q   <= 1'b0;
            req1_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            req0_ack_q <= 1'b0;
            req1_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_d) begin
                        owner_q      <= winner_d;
                        rr_last_q    <= winner_d;
                        mem_enable_q <= 1'b1;
                        mem_write_q  <= cmd_write_d;
                        mem_addr_q   <= cmd_addr_d;
                        mem_data_q   <= cmd_data_d;
                        cnt_q        <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= GRANT;
                    end
                end
                GRANT: begin
                    if (mem_ack_i) begin
                        mem_enable_q <= 1'b0;
                        if (owner_q == PORT_D) begin
                            req1_ack_q <= 1'b1;
                            if (!mem_write_q) req1_data_q <= mem_data_i;
                        end else begin
                            req0_ack_q <= 1'b1;
                            if (!mem_write_q) req0_data_q <= mem_data_i;
                        end
                        state_q <= DONE;
                    end else begin
                        // Flag a stalled memory but keep waiting for it.
                        cnt_q <= cnt_inc_d;
                        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    mem_enable_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign req0_data_o  = req0_data_q;
    assign req0_ack_o   = req0_ack_q;
    assign req1_data_o  = req1_data_q;
    assign req1_ack_o   = req1_ack_q;
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign busy_o       = busy_q;
    assign timeout_o    = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 256;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req0_enable_i, req0_write_i;
    logic [AW-1:0] req0_addr_i;
    logic [DW-1:0] req0_data_i, req0_data_o;
    logic          req0_ack_o;
    logic          req1_enable_i, req1_write_i;
    logic [AW-1:0] req1_addr_i;
    logic [DW-1:0] req1_data_i, req1_data_o;
    logic          req1_ack_o;
    logic          mem_enable_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o, mem_data_i;
    logic          mem_ack_i;
    logic          busy_o, timeout_o;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8), .CNT_W(11)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_enable_i(req0_enable_i), .req0_write_i(req0_write_i),
        .req0_addr_i(req0_addr_i), .req0_data_i(req0_data_i),
        .req0_data_o(req0_data_o), .req0_ack_o(req0_ack_o),
        .req1_enable_i(req1_enable_i), .req1_write_i(req1_write_i),
        .req1_addr_i(req1_addr_i), .req1_data_i(req1_data_i),
        .req1_data_o(req1_data_o), .req1_ack_o(req1_ack_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          port;
        bit          wr;
        logic [31:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic [DW-1:0] exp_data;
        int          dly;
        int          exp_lat;
    } vec_t;

    typedef struct {
        bit            port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] last_data [2];
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every cycle: acks are matched against the scoreboard, idle data must hold.
    task automatic tick();
        logic          ack;
        logic [DW-1:0] dat;
        exp_t          e;
        @(negedge clk_i);
        for (int p = 0; p < 2; p++) begin
            ack = (p == 1) ? req1_ack_o : req0_ack_o;
            dat = (p == 1) ? req1_data_o : req0_data_o;
            if (ack === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: port %0d acked with nothing outstanding", p);
                end else begin
                    e = sb_q.pop_front();
                    chk("ack_port", DW'(p), DW'(e.port));
                    chk("ack_data", dat, e.data);
                    last_data[p] = e.data;
                end
            end else begin
                chk(p == 1 ? "hold_data1" : "hold_data0", dat, last_data[p]);
            end
        end
    endtask

    task automatic raise(input bit port, input bit wr, input logic [31:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] expd);
        exp_t e;
        if (port) begin
            req1_enable_i = 1'b1; req1_write_i = wr; req1_addr_i = addr; req1_data_i = wd;
        end else begin
            req0_enable_i = 1'b1; req0_write_i = wr; req0_addr_i = addr; req0_data_i = wd;
        end
        e.port = port;
        e.data = expd;
        sb_q.push_back(e);
    endtask

    // Memory-side responder: waits for the grant, checks the command, acks after dly cycles.
    task automatic serve(input bit port, input logic [31:0] addr, input bit wr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                         input int dly, input bit hold, output int lat);
        logic [DW-1:0] noise;
        lat = 0;
        while (mem_enable_o !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        chk("grant_seen", DW'(mem_enable_o), DW'(1));
        chk("mem_addr", DW'(mem_addr_o), DW'(addr));
        chk("mem_write", DW'(mem_write_o), DW'(wr));
        chk("busy_grant", DW'(busy_o), DW'(1));
        if (wr) chk("mem_wdata", mem_data_o, wd);
        for (int i = 1; i < dly; i++) begin
            tick();
            chk("enable_held", DW'(mem_enable_o), DW'(1));
            chk("addr_stable", DW'(mem_addr_o), DW'(addr));
            if (wr) chk("wdata_stable", mem_data_o, wd);
        end
        mem_ack_i  = 1'b1;
        mem_data_i = rd;
        tick();
        noise      = {8{$urandom()}};
        mem_ack_i  = 1'b0;
        mem_data_i = noise;
        chk("enable_dropped", DW'(mem_enable_o), DW'(0));
        chk("busy_done", DW'(busy_o), DW'(1));
        if (!hold) begin
            if (port) req1_enable_i = 1'b0;
            else      req0_enable_i = 1'b0;
        end
    endtask

    vec_t          vecs [5];
    int            lat;
    logic [31:0]   t2_addr [2];
    logic [DW-1:0] t2_rd   [4];

    initial begin
        vecs[0] = '{port:1'b1, wr:1'b0, addr:32'h0000_0400, wdata:'0,
                    rdata:{32{8'hA5}}, exp_data:{32{8'hA5}}, dly:3, exp_lat:1};
        vecs[1] = '{port:1'b0, wr:1'b0, addr:32'h0000_1000, wdata:'0,
                    rdata:{8{32'hDEAD_BEEF}}, exp_data:{8{32'hDEAD_BEEF}}, dly:1, exp_lat:1};
        vecs[2] = '{port:1'b0, wr:1'b1, addr:32'h0000_0020, wdata:{16{16'h1234}},
                    rdata:{8{32'h0BAD_F00D}}, exp_data:{8{32'hDEAD_BEEF}}, dly:2, exp_lat:1};
        vecs[3] = '{port:1'b1, wr:1'b1, addr:32'h0000_07FC, wdata:{DW{1'b1}},
                    rdata:{32{8'h5A}}, exp_data:{32{8'hA5}}, dly:1, exp_lat:1};
        vecs[4] = '{port:1'b1, wr:1'b0, addr:32'hFFFF_FFE0, wdata:'0,
                    rdata:'0, exp_data:'0, dly:5, exp_lat:1};

        rst_i = 1'b1;
        req0_enable_i = 0; req0_write_i = 0; req0_addr_i = '0; req0_data_i = '0;
        req1_enable_i = 0; req1_write_i = 0; req1_addr_i = '0; req1_data_i = '0;
        mem_ack_i = 0; mem_data_i = '0;
        last_data[0] = '0;
        last_data[1] = '0;

        tick();
        chk("rst_mem_enable", DW'(mem_enable_o), DW'(0));
        chk("rst_mem_addr", DW'(mem_addr_o), DW'(0));
        chk("rst_mem_data", mem_data_o, '0);
        chk("rst_busy", DW'(busy_o), DW'(0));
        chk("rst_timeout", DW'(timeout_o), DW'(0));
        tick();
        rst_i = 1'b0;
        tick();

        // Single-port transactions from the vector table.
        for (int v = 0; v < 5; v++) begin
            raise(vecs[v].port, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].exp_data);
            serve(vecs[v].port, vecs[v].addr, vecs[v].wr, vecs[v].wdata, vecs[v].rdata,
                  vecs[v].dly, 1'b0, lat);
            chk("grant_latency", DW'(lat), DW'(vecs[v].exp_lat));
            tick();
            chk("idle_after_done", DW'(busy_o), DW'(0));
            chk("sb_drained", DW'(sb_q.size()), DW'(0));
        end

        // Both ports contending: grants must alternate 0,1,0,1.
        t2_addr[0] = 32'h0000_0100;
        t2_addr[1] = 32'h0000_0200;
        for (int i = 0; i < 4; i++) t2_rd[i] = {8{32'hC0DE_0000 + i}};
        raise(1'b0, 1'b0, t2_addr[0], '0, t2_rd[0]);
        raise(1'b1, 1'b0, t2_addr[1], '0, t2_rd[1]);
        for (int g = 0; g < 4; g++) begin
            serve(g[0], t2_addr[g[0]], 1'b0, '0, t2_rd[g], 1, 1'b0, lat);
            if (g < 2) begin
                tick();
                raise(g[0], 1'b0, t2_addr[g[0]], '0, t2_rd[g + 2]);
            end
        end
        tick();
        chk("rr_sb_drained", DW'(sb_q.size()), DW'(0));

        // Port 1 arrives mid-GRANT of a port-0 write and waits for IDLE.
        raise(1'b0, 1'b1, 32'h0000_0020, {16{16'h1234}}, t2_rd[2]);
        tick();
        chk("p0_granted", DW'(mem_addr_o), DW'(32'h20));
        raise(1'b1, 1'b0, 32'h0000_0300, '0, {8{32'h1111_2222}});
        serve(1'b0, 32'h0000_0020, 1'b1, {16{16'h1234}}, {8{32'h9999_9999}}, 4, 1'b0, lat);
        serve(1'b1, 32'h0000_0300, 1'b0, '0, {8{32'h1111_2222}}, 1, 1'b0, lat);
        chk("late_p1_latency", DW'(lat), DW'(2));
        tick();

        // Spurious memory ack in IDLE, then port 0 holding its enable through DONE.
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;
        tick();
        chk("spurious_no_ack0", DW'(req0_ack_o), DW'(0));
        chk("spurious_no_ack1", DW'(req1_ack_o), DW'(0));
        chk("spurious_idle", DW'(busy_o), DW'(0));
        raise(1'b0, 1'b0, 32'h0000_0040, '0, {8{32'hAAAA_0001}});
        serve(1'b0, 32'h0000_0040, 1'b0, '0, {8{32'hAAAA_0001}}, 1, 1'b1, lat);
        tick();
        chk("no_regrant_in_done", DW'(mem_enable_o), DW'(0));
        chk("idle_with_stale_en", DW'(busy_o), DW'(0));
        raise(1'b0, 1'b0, 32'h0000_0040, '0, {8{32'hAAAA_0002}});
        serve(1'b0, 32'h0000_0040, 1'b0, '0, {8{32'hAAAA_0002}}, 1, 1'b0, lat);
        chk("regrant_latency", DW'(lat), DW'(1));
        tick();

        // Watchdog: no ack for 8 GRANT cycles, then a late ack.
        raise(1'b1, 1'b0, 32'h0000_0880, '0, {8{32'h600D_CAFE}});
        tick();
        for (int c = 1; c <= 8; c++) begin
            chk("timeout_early", DW'(timeout_o), DW'(0));
            chk("wd_enable_held", DW'(mem_enable_o), DW'(1));
            tick();
        end
        chk("timeout_set", DW'(timeout_o), DW'(1));
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("timeout_sticky", DW'(timeout_o), DW'(1));
            chk("wd_still_waiting", DW'(mem_enable_o), DW'(1));
        end
        serve(1'b1, 32'h0000_0880, 1'b0, '0, {8{32'h600D_CAFE}}, 1, 1'b0, lat);
        tick();
        chk("timeout_after_ack", DW'(timeout_o), DW'(1));
        chk("wd_sb_drained", DW'(sb_q.size()), DW'(0));

        // Asynchronous reset in the middle of a GRANT.
        raise(1'b0, 1'b0, 32'h0000_0500, '0, {8{32'hBAD0_BAD0}});
        tick();
        tick();
        chk("pre_rst_grant", DW'(mem_enable_o), DW'(1));
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_enable", DW'(mem_enable_o), DW'(0));
        chk("async_rst_busy", DW'(busy_o), DW'(0));
        chk("async_rst_timeout", DW'(timeout_o), DW'(0));
        chk("async_rst_addr", DW'(mem_addr_o), DW'(0));
        chk("async_rst_data0", req0_data_o, '0);
        chk("async_rst_data1", req1_data_o, '0);
        sb_q.delete();
        last_data[0] = '0;
        last_data[1] = '0;
        req0_enable_i = 1'b0;
        tick();
        rst_i = 1'b0;
        mem_ack_i = 1'b1;
        mem_data_i = {8{32'hBAD0_BAD0}};
        tick();
        mem_ack_i = 1'b0;
        tick();
        chk("killed_no_ack0", DW'(req0_ack_o), DW'(0));
        chk("killed_no_ack1", DW'(req1_ack_o), DW'(0));
        chk("killed_idle", DW'(busy_o), DW'(0));

        // After reset port 0 wins the first tie again.
        raise(1'b0, 1'b0, 32'h0000_0600, '0, {8{32'h0000_0006}});
        raise(1'b1, 1'b0, 32'h0000_0700, '0, {8{32'h0000_0007}});
        serve(1'b0, 32'h0000_0600, 1'b0, '0, {8{32'h0000_0006}}, 1, 1'b0, lat);
        serve(1'b1, 32'h0000_0700, 1'b0, '0, {8{32'h0000_0007}}, 2, 1'b0, lat);
        tick();
        chk("final_sb_drained", DW'(sb_q.size()), DW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 256-bit off-chip memory port between two cache requesters: port 0 is the instruction cache and port 1 is the data cache (Dcache_Top).
- Sits between the CPU's cache units and Data_Memory.
- Grants one whole transaction at a time, using round-robin priority.
- Registers the memory command, returns read data and a one-cycle ack to the winner, and flags memory-side hangs with a sticky timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 256, cache-line width
TIMEOUT_CYCLES, 1024, cycles in GRANT without mem_ack_i before timeout_o sets
CNT_W, 11, watchdog counter width (must hold TIMEOUT_CYCLES)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req0_enable_i  in  1  port-0 request; held until req0_ack_o
req0_write_i  in  1  port-0 write (1) / read (0)
req0_addr_i  in  ADDR_W  port-0 line address
req0_data_i  in  DATA_W  port-0 write data
req0_data_o  out  DATA_W  port-0 read data, valid with req0_ack_o
req0_ack_o  out  1  port-0 completion pulse
req1_enable_i, req1_write_i, req1_addr_i, req1_data_i, req1_data_o, req1_ack_o  same as port 0, for port 1
mem_enable_o  out  1  memory request, held until mem_ack_i
mem_write_o  out  1  memory write
mem_addr_o  out  ADDR_W  memory address
mem_data_o  out  DATA_W  memory write data
mem_data_i  in  DATA_W  memory read data, valid with mem_ack_i
mem_ack_i  in  1  memory completion pulse
busy_o  out  1  high in GRANT or DONE
timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; rr_last=1, so port 0 wins the first tie.
  - All outputs 0, including data outputs; watchdog count 0; timeout_o 0.
- States: IDLE, GRANT, DONE. Encoding lives in the package.
- IDLE:
  - If any reqN_enable_i=1, pick a winner:
    - Only one requesting: that port.
    - Both requesting: the port != rr_last.
  - On the pick edge, register the winner's write/addr/data into mem_*_o, set mem_enable_o=1, set owner=winner, set rr_last=winner, go to GRANT.
  - No request: stay in IDLE.
- GRANT:
  - mem_enable_o and the command outputs stay stable.
  - mem_ack_i=1 on an edge:
    - mem_enable_o←0.
    - reqOwner_data_o←mem_data_i (read only; unchanged on writes).
    - reqOwner_ack_o←1 for exactly one cycle.
    - Go to DONE.
- DONE:
  - Lasts one cycle; the ack pulse is visible here. The requester drops its enable this cycle.
  - Go to IDLE. No arbitration happens in DONE, so a stale enable is never re-granted.
- Latency:
  - Request first seen at edge 0 → mem_enable_o high after edge 0.
  - mem_ack_i sampled at edge k → ack_o/data_o high for the cycle after edge k.
  - IDLE after edge k+1.
  - Minimum turnaround, with the ack in the first GRANT cycle, is 3 cycles from request to re-arbitration.
- Port independence:
  - The non-owner's enable is ignored until IDLE.
  - The non-owner's ack_o stays 0 and its data_o holds its last value.
- Owner dropping its enable mid-GRANT: the transaction still completes and is acked. Memory state stays consistent.
- mem_ack_i in IDLE/DONE: ignored, no ack_o.
- Watchdog:
  - The counter clears on GRANT entry and increments each GRANT cycle, saturating at its maximum.
  - When count==TIMEOUT_CYCLES-1 and there is no ack, timeout_o←1. It stays set until reset.
  - The arbiter keeps waiting; it never abandons a transaction.
- Reset mid-GRANT:
  - Immediate IDLE with all outputs 0.
  - A later mem_ack_i for the killed transaction arrives in IDLE and is ignored.
- busy_o = (state != IDLE), registered with the state.

Decomposition:
- Package mem_arb_pkg:
  - State enum/localparams (IDLE=2'd0, GRANT=2'd1, DONE=2'd2).
  - Port indices PORT_I=0, PORT_D=1.
  - Default widths.
- Sub-module rr_select (combinational):
  - Inputs: req[1:0], last.
  - Outputs: any, winner.
  - Instantiated once.
- The FSM, command registers, return-data registers and watchdog stay in mem_port_arbiter.

Test Plan:
1. Port 1 read addr 0x0000_0400, memory acks 3 cycles after mem_enable_o with data 0xA5…A5 → mem_addr_o=0x400, mem_write_o=0, mem_enable_o high 3 cycles; req1_ack_o single pulse with req1_data_o=0xA5…A5; req0_ack_o never asserts.
2. Both ports request from reset, repeatedly → grants alternate 0,1,0,1; port 0 addr/data appear on mem_* first; each ack goes only to its owner.
3. Port 0 write addr 0x20 data 0x1234…, port 1 raises its request mid-GRANT → port 1 is not granted until IDLE; port 0's write data sits unchanged on mem_data_o throughout GRANT.
4. Memory never acks, TIMEOUT_CYCLES=8 → timeout_o rises after the 8th GRANT cycle and stays high; mem_enable_o stays high; a late ack still completes the transaction and timeout_o stays 1.
5. Reset asserted asynchronously mid-GRANT, then mem_ack_i pulses → all outputs 0 immediately; the ack is ignored and produces no reqN_ack_o.
6. Spurious mem_ack_i in IDLE, and port 0 holding its enable through DONE → no ack_o; port 0 is re-granted only on the cycle after DONE, in IDLE.
